// File: rtl/iob_uart_lite.sv
// Native-bus UART responder: register map plus 8N1 TX/RX engines.
// Define UART_ERR_EN to add sticky framing/overrun flags in STATUS.
module iob_uart_lite #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 4,
  parameter logic [15:0] DIV_RST = 16'd868
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              txd,
  input  logic              rxd
);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_t;

  logic              ready_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [15:0]       div_q, div_d, div_eff;
  logic              txen_q, txen_d;
  logic              rxen_q, rxen_d;

  st_t         tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d;

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  st_t         rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        rxrdy_q, rxrdy_d;
  logic        rx_done, rx_bad;
`ifdef UART_ERR_EN
  logic [1:0]  err_q, err_d;
`endif

  logic acc, wr, rd, srst, tx_rdy, rd7, rd8;
  logic [DATA_W-1:0] unused_wdata;

  assign unused_wdata = wdata;
  assign acc    = valid & ~ready_q;
  assign wr     = acc & (wstrb != 4'd0);
  assign rd     = acc & (wstrb == 4'd0);
  assign srst   = wr & (addr == ADDR_W'(0));
  assign rd7    = rd & (addr == ADDR_W'(7));
  assign rd8    = rd & (addr == ADDR_W'(8));
  assign tx_rdy = txen_q & (tx_st_q == S_IDLE);
  assign div_eff = (div_q < 16'd2) ? 16'd2 : div_q;

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign txd   = txd_q;

  always_comb begin
    div_d   = div_q;
    txen_d  = txen_q;
    rxen_d  = rxen_q;
    rdata_d = '0;
    if (wr) begin
      case (addr)
        ADDR_W'(1): div_d  = wdata[15:0];
        ADDR_W'(3): txen_d = wdata[0];
        ADDR_W'(4): rxen_d = wdata[0];
        default: ;
      endcase
    end
    if (rd) begin
      case (addr)
        ADDR_W'(5): rdata_d = DATA_W'(tx_rdy);
        ADDR_W'(6): rdata_d = DATA_W'(rxrdy_q);
        ADDR_W'(7): rdata_d = DATA_W'(rx_buf_q);
`ifdef UART_ERR_EN
        ADDR_W'(8): rdata_d = DATA_W'(err_q);
`endif
        default:    rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    case (tx_st_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (wr && addr == ADDR_W'(2) && tx_rdy) begin
          tx_st_d  = S_START;
          tx_cnt_d = div_eff - 16'd1;
          tx_sh_d  = wdata[7:0];
          txd_d    = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_st_d  = S_DATA;
          tx_cnt_d = div_eff - 16'd1;
          tx_bit_d = 3'd0;
          txd_d    = tx_sh_q[0];
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_eff - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (tx_cnt_q == 16'd0) tx_st_d = S_IDLE;
        else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_done  = 1'b0;
    rx_bad   = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_st_d  = S_START;
          rx_cnt_d = {1'b0, div_eff[15:1]} - 16'd1;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          // A start bit that is high again mid-bit was only a glitch
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
          rx_cnt_d = div_eff - 16'd1;
          rx_bit_d = 3'd0;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = div_eff - 16'd1;
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_st_d = S_IDLE;
          rx_done = 1'b1;
          rx_bad  = ~rx_s2_q;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_st_d = S_IDLE;
    endcase
    if (!rxen_q) begin
      rx_st_d = S_IDLE;
      rx_done = 1'b0;
      rx_bad  = 1'b0;
    end
  end

  always_comb begin
    rx_buf_d = rx_buf_q;
    rxrdy_d  = rxrdy_q & ~rd7;
`ifdef UART_ERR_EN
    err_d = rd8 ? 2'b00 : err_q;
    if (rx_done) begin
      rx_buf_d = rx_sh_q;
      rxrdy_d  = 1'b1;
      if (rx_bad) err_d[0] = 1'b1;
      if (rxrdy_q && !rd7) err_d[1] = 1'b1;
    end
`else
    if (rx_done && !rx_bad) begin
      rx_buf_d = rx_sh_q;
      rxrdy_d  = 1'b1;
    end
`endif
  end

  // Handshake and DIV survive SOFTRESET so its own write still completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      div_q   <= DIV_RST;
    end else begin
      ready_q <= acc;
      rdata_q <= rdata_d;
      div_q   <= div_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || srst) begin
      txen_q    <= 1'b0;
      rxen_q    <= 1'b0;
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      txd_q     <= 1'b1;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_buf_q  <= '0;
      rxrdy_q   <= 1'b0;
`ifdef UART_ERR_EN
      err_q     <= 2'b00;
`endif
    end else begin
      txen_q    <= txen_d;
      rxen_q    <= rxen_d;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      txd_q     <= txd_d;
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_buf_q  <= rx_buf_d;
      rxrdy_q   <= rxrdy_d;
`ifdef UART_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_iob_uart_lite.sv
// Bench for iob_uart_lite: register table, TX waveform, RX loopback,
// glitch/framing/overrun and SOFTRESET sequences.
module tb_iob_uart_lite;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_r = 1'b0;
  logic [3:0]  addr_r = '0;
  logic [31:0] wdata_r = '0;
  logic [3:0]  wstrb_r = '0;
  logic [31:0] rdata;
  logic        ready, txd, rxd_w;
  logic        rxd_drv = 1'b1;
  logic        loop_en = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  assign rxd_w = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  iob_uart_lite #(
    .DATA_W(32), .ADDR_W(4), .DIV_RST(16'd868)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid_r),
    .addr(addr_r), .wdata(wdata_r), .wstrb(wstrb_r),
    .rdata(rdata), .ready(ready), .txd(txd), .rxd(rxd_w)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic [3:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd);
    int n;
    rd = '0;
    addr_r = a; wdata_r = wd; wstrb_r = st; valid_r = 1'b1;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!ready && n < 20);
    if (ready) rd = rdata;
    else begin
      n_chk++;
      n_fail++;
      $display("FAIL bus_timeout: addr %0d got no ready, required 1", a);
    end
    valid_r = 1'b0;
    wstrb_r = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(a, d, 4'hF, dummy);
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp,
                        input string nm);
    logic [31:0] got, e;
    exp_q.push_back(exp);
    bus(a, 32'd0, 4'd0, got);
    e = exp_q.pop_front();
    chk(nm, got, e);
  endtask

  task automatic low_len(output int n);
    n = 0;
    while (txd == 1'b0 && n < 2000) begin
      n++;
      cyc(1);
    end
  endtask

  task automatic poll_rx(output logic ok);
    logic [31:0] r;
    ok = 1'b0;
    for (int i = 0; i < 150 && !ok; i++) begin
      bus(4'd6, 32'd0, 4'd0, r);
      ok = r[0];
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    rxd_drv = 1'b0;
    cyc(8);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      cyc(8);
    end
    rxd_drv = stopb;
    cyc(8);
    rxd_drv = 1'b1;
    cyc(16);
  endtask

  initial begin
    int          len;
    logic        ok;
    logic        rec[40];
    logic [9:0]  pat;
    logic [3:0]  hs_exp;

    vecs[0]  = '{4'd5,  32'd0,  4'd0, 32'd0};
    vecs[1]  = '{4'd6,  32'd0,  4'd0, 32'd0};
    vecs[2]  = '{4'd7,  32'd0,  4'd0, 32'd0};
    vecs[3]  = '{4'd8,  32'd0,  4'd0, 32'd0};
    vecs[4]  = '{4'd9,  32'd0,  4'd0, 32'd0};
    vecs[5]  = '{4'd9,  32'hFFFF_FFFF, 4'hF, 32'd0};
    vecs[6]  = '{4'd15, 32'd0,  4'd0, 32'd0};
    vecs[7]  = '{4'd3,  32'd1,  4'h1, 32'd0};
    vecs[8]  = '{4'd5,  32'd0,  4'd0, 32'd1};
    vecs[9]  = '{4'd4,  32'd1,  4'h1, 32'd0};
    vecs[10] = '{4'd6,  32'd0,  4'd0, 32'd0};
    vecs[11] = '{4'd3,  32'd0,  4'h1, 32'd0};
    vecs[12] = '{4'd5,  32'd0,  4'd0, 32'd0};
    vecs[13] = '{4'd4,  32'd0,  4'h1, 32'd0};

    cyc(2);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    cyc(1);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wstrb != 4'd0) wr(vecs[i].addr, vecs[i].wdata);
      else rd_chk(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // held valid: answered every other cycle
    cyc(2);
    hs_exp = 4'b0101;
    addr_r = 4'd5; wstrb_r = 4'd0; valid_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk($sformatf("hs%0d", i), 32'(ready), 32'(hs_exp[i]));
    end
    valid_r = 1'b0;
    cyc(2);

    // reset DIV: start bit lasts DIV_RST clocks
    wr(4'd3, 32'd1);
    wr(4'd2, 32'hFF);
    low_len(len);
    chk("div_rst", 32'(len), 32'd868);
    wr(4'd0, 32'd0);
    chk("srst_txd0", 32'(txd), 32'd1);
    rd_chk(4'd5, 32'd0, "srst_txen0");

    // TX frame of 0xA5 at DIV=4
    wr(4'd1, 32'd4);
    wr(4'd3, 32'd1);
    wr(4'd2, 32'hA5);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          rec[i] = txd;
          cyc(1);
        end
      end
      begin
        cyc(3);
        rd_chk(4'd5, 32'd0, "txready_busy");
        wr(4'd2, 32'h00);
      end
    join
    pat = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++)
      chk($sformatf("tx_bit%0d", i), 32'(rec[i]), 32'(pat[i/4]));
    rd_chk(4'd5, 32'd1, "txready_idle");
    chk("tx_idle_txd", 32'(txd), 32'd1);

    // DIV below 2 behaves as 2
    wr(4'd1, 32'd1);
    wr(4'd2, 32'hFF);
    low_len(len);
    chk("div_min", 32'(len), 32'd2);
    cyc(30);

    // loopback 0x3C at DIV=8
    loop_en = 1'b1;
    wr(4'd1, 32'd8);
    wr(4'd4, 32'd1);
    wr(4'd2, 32'h3C);
    poll_rx(ok);
    chk("loop_rxready", 32'(ok), 32'd1);
    rd_chk(4'd7, 32'h3C, "loop_rxdata");
    rd_chk(4'd6, 32'd0, "loop_rxready_clr");
    cyc(20);
    loop_en = 1'b0;
    cyc(4);

    // two-clock glitch is not a start bit
    rxd_drv = 1'b0;
    cyc(2);
    rxd_drv = 1'b1;
    cyc(200);
    rd_chk(4'd6, 32'd0, "glitch_rxready");

    // stop bit low
    send_rx(8'h5A, 1'b0);
`ifdef UART_ERR_EN
    rd_chk(4'd8, 32'd1, "frm_status");
    rd_chk(4'd8, 32'd0, "frm_status_clr");
    rd_chk(4'd6, 32'd1, "frm_rxready");
    rd_chk(4'd7, 32'h5A, "frm_rxdata");
`else
    rd_chk(4'd6, 32'd0, "frm_rxready");
    rd_chk(4'd8, 32'd0, "frm_status");
`endif

    // overrun: second byte replaces unread first
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd_chk(4'd6, 32'd1, "ovr_rxready");
    rd_chk(4'd7, 32'h22, "ovr_rxdata");
`ifdef UART_ERR_EN
    rd_chk(4'd8, 32'd2, "ovr_status");
`else
    rd_chk(4'd8, 32'd0, "ovr_status");
`endif

    // SOFTRESET mid-frame, DIV kept at 8
    wr(4'd3, 32'd1);
    wr(4'd2, 32'h00);
    cyc(12);
    chk("srst_pre_txd", 32'(txd), 32'd0);
    wr(4'd0, 32'h1234);
    chk("srst_txd", 32'(txd), 32'd1);
    rd_chk(4'd5, 32'd0, "srst_txready");
    rd_chk(4'd6, 32'd0, "srst_rxready");
    wr(4'd3, 32'd1);
    wr(4'd2, 32'hFF);
    low_len(len);
    chk("srst_div_kept", 32'(len), 32'd8);
    cyc(100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
